soc1_ram_dp: RTL and testbench

SOC1_RAM_DP -- requirements
Module: soc1_ram_dp

---
 rtl/soc1_ram_dp.sv | 154 +++++++++++++++
 tb/tb_soc1_ram_dp.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc1_ram_dp.sv
// Dual-port Avalon-MM word RAM with byte enables, zero-fill after reset
// and a 1- or 2-cycle read pipeline that freezes while clken is low.
module soc1_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int DEPTH          = 10240,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  wait_all;

    logic [ADDR_WIDTH-1:0] addr   [2];
    logic                  cs     [2];
    logic                  rd     [2];
    logic                  wr     [2];
    logic [NB-1:0]         be     [2];
    logic [DATA_WIDTH-1:0] wd     [2];
    logic                  acc_rd [2];
    logic                  wr_ok  [2];
    logic [IW-1:0]         idx    [2];
    logic [DATA_WIDTH-1:0] mem_q  [2];

    assign addr[0] = s1_address;
    assign cs[0]   = s1_chipselect;
    assign rd[0]   = s1_read;
    assign wr[0]   = s1_write;
    assign be[0]   = s1_byteenable;
    assign wd[0]   = s1_writedata;
    assign addr[1] = s2_address;
    assign cs[1]   = s2_chipselect;
    assign rd[1]   = s2_read;
    assign wr[1]   = s2_write;
    assign be[1]   = s2_byteenable;
    assign wd[1]   = s2_writedata;

    // Gating with reset_n keeps both ports stalled during reset even
    // when the clear phase is skipped.
    assign init_done      = reset_n & (state == ST_READY);
    assign wait_all       = ~init_done | ~clken;
    assign s1_waitrequest = wait_all;
    assign s2_waitrequest = wait_all;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else if (clken && state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == LAST)
                state <= ST_READY;
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            logic acc;
            logic in_rng;
            acc       = cs[n] & (rd[n] | wr[n]) & ~wait_all;
            in_rng    = {1'b0, addr[n]} < DEPTH_W;
            acc_rd[n] = acc & rd[n] & ~wr[n];
            wr_ok[n]  = acc & wr[n] & in_rng;
            idx[n]    = addr[n][IW-1:0];
            mem_q[n]  = in_rng ? mem[idx[n]] : '0;
        end
    end

    // Port 1 is written last so it owns any lane both ports enable.
    always_ff @(posedge clk) begin
        if (clken && state == ST_CLEAR)
            mem[clr_cnt[IW-1:0]] <= '0;
        for (int b = 0; b < NB; b++) begin
            if (wr_ok[1] && be[1][b])
                mem[idx[1]][8*b +: 8] <= wd[1][8*b +: 8];
            if (wr_ok[0] && be[0][b])
                mem[idx[0]][8*b +: 8] <= wd[0][8*b +: 8];
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_rd
        logic                  pv;
        logic [DATA_WIDTH-1:0] pd;
        logic                  ov;
        logic [DATA_WIDTH-1:0] od;

        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pv <= 1'b0;
                    pd <= '0;
                end else if (clken) begin
                    pv <= acc_rd[n];
                    if (acc_rd[n])
                        pd <= mem_q[n];
                end
            end
        end else begin : g_lat1
            assign pv = acc_rd[n];
            assign pd = mem_q[n];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ov <= 1'b0;
                od <= '0;
            end else begin
                ov <= clken & pv;
                if (clken && pv)
                    od <= pd;
            end
        end
    end

    assign s1_readdatavalid = g_rd[0].ov;
    assign s1_readdata      = g_rd[0].od;
    assign s2_readdatavalid = g_rd[1].ov;
    assign s2_readdata      = g_rd[1].od;

endmodule

// File: tb/tb_soc1_ram_dp.sv
// Randomized and directed bench for soc1_ram_dp: two instances (latency 1
// and 2) share stimulus and are checked against one behavioural model.
module tb_soc1_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clken;
    logic [AW-1:0] addr [2];
    logic          cs   [2];
    logic          rd   [2];
    logic          wr   [2];
    logic [3:0]    be   [2];
    logic [DW-1:0] wd   [2];

    logic [DW-1:0] rdd [2][2];
    logic          rdv [2][2];
    logic          wrq [2][2];
    logic          idn [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        soc1_ram_dp #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
            .READ_LATENCY(i + 1), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .clken(clken),
            .s1_address(addr[0]), .s1_chipselect(cs[0]),
            .s1_read(rd[0]), .s1_write(wr[0]),
            .s1_byteenable(be[0]), .s1_writedata(wd[0]),
            .s1_readdata(rdd[i][0]), .s1_readdatavalid(rdv[i][0]),
            .s1_waitrequest(wrq[i][0]),
            .s2_address(addr[1]), .s2_chipselect(cs[1]),
            .s2_read(rd[1]), .s2_write(wr[1]),
            .s2_byteenable(be[1]), .s2_writedata(wd[1]),
            .s2_readdata(rdd[i][1]), .s2_readdatavalid(rdv[i][1]),
            .s2_waitrequest(wrq[i][1]),
            .init_done(idn[i])
        );
    end

    // Model: reads are tagged with the clken-edge number that accepted
    // them; latency L returns a read L-1 clken edges later.
    typedef struct {
        logic [DW-1:0] d;
        int            k;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    rd_t           pq [2][$];
    int            ce;
    int            clear_left;
    bit            ready;
    logic          ev [2][2];
    logic [DW-1:0] ed [2][2];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    task automatic model_reset();
        ready      = 1'b0;
        clear_left = DEPTH;
        ce         = 0;
        pq[0].delete();
        pq[1].delete();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                ev[i][p] = 1'b0;
                ed[i][p] = '0;
            end
    endtask

    task automatic model_edge();
        bit  acc_r [2];
        bit  acc_w [2];
        rd_t t;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                ev[i][p] = 1'b0;
        if (!reset_n || !clken)
            return;
        if (!ready) begin
            clear_left--;
            if (clear_left == 0) begin
                ready = 1'b1;
                foreach (mem_m[a]) mem_m[a] = '0;
            end
            return;
        end
        ce++;
        for (int p = 0; p < 2; p++) begin
            acc_w[p] = cs[p] && wr[p];
            acc_r[p] = cs[p] && rd[p] && !wr[p];
            if (acc_r[p]) begin
                t.k = ce;
                t.d = '0;
                if (int'(addr[p]) < DEPTH)
                    t.d = mem_m[int'(addr[p])];
                pq[p].push_back(t);
            end
        end
        for (int p = 1; p >= 0; p--)
            if (acc_w[p] && int'(addr[p]) < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (be[p][b])
                        mem_m[int'(addr[p])][8*b +: 8] = wd[p][8*b +: 8];
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                for (int j = 0; j < pq[p].size(); j++)
                    if (pq[p][j].k + i == ce) begin
                        ev[i][p] = 1'b1;
                        ed[i][p] = pq[p][j].d;
                    end
        for (int p = 0; p < 2; p++)
            while (pq[p].size() > 0 && pq[p][0].k + 1 <= ce)
                void'(pq[p].pop_front());
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("init_done L%0d", i + 1),
                32'(idn[i]), 32'(reset_n && ready));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("waitrequest L%0d s%0d", i + 1, p + 1),
                    32'(wrq[i][p]), 32'(!reset_n || !ready || !clken));
                chk($sformatf("readdatavalid L%0d s%0d", i + 1, p + 1),
                    32'(rdv[i][p]), 32'(reset_n && ev[i][p]));
                chk($sformatf("readdata L%0d s%0d", i + 1, p + 1),
                    rdd[i][p], reset_n ? ed[i][p] : '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0;
            rd[p] = 1'b0;
            wr[p] = 1'b0;
        end
    endtask

    task automatic cmd(int p, logic r, logic w, logic [AW-1:0] a,
                       logic [DW-1:0] d, logic [3:0] b);
        cs[p]   = 1'b1;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = a;
        wd[p]   = d;
        be[p]   = b;
    endtask

    task automatic read_lit(int p, logic [AW-1:0] a, logic [DW-1:0] e);
        bit seen [2];
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        idle();
        cmd(p, 1'b1, 1'b0, a, '0, 4'h0);
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (!seen[i] && rdv[i][p]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("lit read s%0d L%0d", p + 1, i + 1),
                        rdd[i][p], e);
                end
            tick();
        end
        for (int i = 0; i < 2; i++)
            if (!seen[i]) begin
                n_vec++;
                n_err++;
                $display("FAIL lit read timeout s%0d L%0d: got no valid, expected %h",
                         p + 1, i + 1, e);
            end
    endtask

    task automatic check_clear();
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            chk("clear waitrequest", 32'(wrq[0][0] & wrq[1][1]), 32'd1);
            chk("clear init_done", 32'(idn[0] | idn[1]), 32'd0);
            chk("clear no valid",
                32'({rdv[0][0], rdv[0][1], rdv[1][0], rdv[1][1]}), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("init_done rise", 32'(idn[0] & idn[1]), 32'd1);
        chk("ready waitrequest", 32'(wrq[0][0] | wrq[1][1]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        clken   = 1'b1;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0;
            be[p]   = '0;
            wd[p]   = '0;
        end
        idle();
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        check_clear();

        for (int a = 0; a < DEPTH; a++) begin
            cmd(0, 1'b1, 1'b0, AW'(a), '0, 4'h0);
            cmd(1, 1'b1, 1'b0, AW'(DEPTH - 1 - a), '0, 4'h0);
            tick();
        end
        idle();
        repeat (3) tick();

        cmd(0, 1'b0, 1'b1, 5'd5, 32'hAABBCCDD, 4'b1111);
        tick();
        cmd(0, 1'b0, 1'b1, 5'd5, 32'h11223344, 4'b0101);
        tick();
        read_lit(0, 5'd5, 32'hAA22CC44);

        cmd(0, 1'b0, 1'b1, 5'd7, 32'hFFFFFFFF, 4'b0011);
        cmd(1, 1'b0, 1'b1, 5'd7, 32'h12345678, 4'b1111);
        tick();
        read_lit(1, 5'd7, 32'h1234FFFF);
        read_lit(0, 5'd20, 32'h0);

        for (int a = 1; a <= 3; a++) begin
            idle();
            cmd(1, 1'b0, 1'b1, AW'(a), 32'h1111_0000 * a + a, 4'hF);
            tick();
        end
        cmd(1, 1'b1, 1'b0, 5'd1, '0, 4'h0);
        tick();
        cmd(1, 1'b1, 1'b0, 5'd2, '0, 4'h0);
        @(negedge clk);
        chk("lat2 first cycle valid", 32'(rdv[1][1]), 32'd0);
        tick();
        cmd(1, 1'b1, 1'b0, 5'd3, '0, 4'h0);
        @(negedge clk);
        chk("lat2 valid 1", 32'(rdv[1][1]), 32'd1);
        chk("lat2 data 1", rdd[1][1], 32'h1111_0001);
        tick();
        idle();
        @(negedge clk);
        chk("lat2 valid 2", 32'(rdv[1][1]), 32'd1);
        chk("lat2 data 2", rdd[1][1], 32'h2222_0002);
        tick();
        @(negedge clk);
        chk("lat2 valid 3", 32'(rdv[1][1]), 32'd1);
        chk("lat2 data 3", rdd[1][1], 32'h3333_0003);
        tick();
        @(negedge clk);
        chk("lat2 valid end", 32'(rdv[1][1]), 32'd0);
        chk("lat2 data hold", rdd[1][1], 32'h3333_0003);
        repeat (2) tick();

        cmd(0, 1'b1, 1'b0, 5'd5, '0, 4'h0);
        tick();
        idle();
        clken = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall waitrequest",
                32'(wrq[0][0] & wrq[0][1] & wrq[1][0] & wrq[1][1]), 32'd1);
            chk("stall no valid", 32'(rdv[1][0]), 32'd0);
            tick();
        end
        clken = 1'b1;
        @(negedge clk);
        chk("stall held", 32'(rdv[1][0]), 32'd0);
        tick();
        @(negedge clk);
        chk("stall release valid", 32'(rdv[1][0]), 32'd1);
        chk("stall release data", rdd[1][0], 32'hAA22CC44);
        tick();

        cmd(0, 1'b1, 1'b0, 5'd5, '0, 4'h0);
        cmd(1, 1'b1, 1'b0, 5'd7, '0, 4'h0);
        tick();
        idle();
        @(negedge clk);
        chk("inflight not returned", 32'(rdv[1][0] | rdv[1][1]), 32'd0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset valid", 32'({rdv[0][0], rdv[0][1], rdv[1][0], rdv[1][1]}), 32'd0);
        chk("reset data", rdd[1][0] | rdd[0][0], 32'd0);
        tick();
        reset_n = 1'b1;
        check_clear();
        read_lit(0, 5'd5, 32'h0);
        read_lit(1, 5'd7, 32'h0);

        for (int c = 0; c < 2000; c++) begin
            clken = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = 1'($urandom_range(0, 1));
                wr[p]   = ($urandom_range(0, 2) == 0);
                addr[p] = (c % 3 == 0) ? AW'($urandom_range(0, 3))
                                       : AW'($urandom_range(0, 19));
                be[p]   = 4'($urandom);
                wd[p]   = $urandom;
            end
            if ($urandom_range(0, 699) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else begin
                reset_n = 1'b1;
            end
            tick();
        end
        reset_n = 1'b1;
        clken   = 1'b1;
        idle();
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
